// File: rtl/pe_row_feeder_if.sv
// Stream and PE-side bus of pe_row_feeder: weight/ifmap input streams, PE drive/return
// ports and the psum output stream. The feeder takes the slave side.
interface pe_row_feeder_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PSUM_W = 32
);
  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;
  logic              x_valid;
  logic              x_ready;
  logic [DATA_W-1:0] x_data;
  logic [DATA_W-1:0] pe_weight_val;
  logic              pe_weight_en;
  logic [DATA_W-1:0] pe_image_val;
  logic              pe_image_en;
  logic [PSUM_W-1:0] pe_psum_in;
  logic [PSUM_W-1:0] pe_psum_out;
  logic              out_valid;
  logic              out_ready;
  logic [PSUM_W-1:0] out_data;

  modport slave (
    input  w_valid, w_data, x_valid, x_data, pe_psum_out, out_ready,
    output w_ready, x_ready, pe_weight_val, pe_weight_en, pe_image_val, pe_image_en,
           pe_psum_in, out_valid, out_data
  );

  modport master (
    output w_valid, w_data, x_valid, x_data, pe_psum_out, out_ready,
    input  w_ready, x_ready, pe_weight_val, pe_weight_en, pe_image_val, pe_image_en,
           pe_psum_in, out_valid, out_data
  );
endinterface

// File: rtl/pe_row_feeder.sv
// Buffers one K-tap filter row and one N-element ifmap row, then sequences a single PE
// tap-by-tap through a 1-D convolution, closing its psum loop and streaming N-K+1 results.
module pe_row_feeder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PSUM_W = 32,
  parameter int unsigned K      = 3,
  parameter int unsigned N      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  pe_row_feeder_if.slave   bus
);

  localparam int unsigned WcW = $clog2(K + 1);
  localparam int unsigned XcW = $clog2(N + 1);
  localparam int unsigned KiW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned XiW = (N > 1) ? $clog2(N) : 1;

  localparam logic [WcW-1:0] KFull = WcW'(K);
  localparam logic [XcW-1:0] NFull = XcW'(N);
  localparam logic [KiW-1:0] KLast = KiW'(K - 1);
  localparam logic [XiW-1:0] OLast = XiW'(N - K);

  typedef enum logic [2:0] {StIdle, StLoad, StLdW, StIssue, StCap, StOut} state_e;

  state_e            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_wbuf [K];
  logic [DATA_W-1:0] r_xbuf [N];
  logic [WcW-1:0]    r_wcnt;
  logic [XcW-1:0]    r_xcnt;
  logic [KiW-1:0]    r_k;
  logic [XiW-1:0]    r_o;
  logic [PSUM_W-1:0] r_acc;
  logic              r_done;

  logic             w_w_fire, w_x_fire, w_out_fire, w_load_full;
  logic [XiW-1:0]   w_xidx;

  assign w_xidx      = r_o + XiW'(r_k);
  assign w_load_full = (r_wcnt == KFull) && (r_xcnt == NFull);
  assign w_w_fire    = bus.w_valid && bus.w_ready;
  assign w_x_fire    = bus.x_valid && bus.x_ready;
  assign w_out_fire  = (r_state == StOut) && bus.out_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (i_start) w_state_nxt = StLoad;
      StLoad:  if (w_load_full) w_state_nxt = StLdW;
      StLdW:   w_state_nxt = StIssue;
      StIssue: w_state_nxt = StCap;
      StCap:   w_state_nxt = (r_k == KLast) ? StOut : StLdW;
      StOut:   if (bus.out_ready) w_state_nxt = (r_o == OLast) ? StIdle : StLdW;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Outputs decode only from registered state, so no input reaches an output combinationally.
  always_comb begin
    bus.w_ready       = 1'b0;
    bus.x_ready       = 1'b0;
    bus.pe_weight_en  = 1'b0;
    bus.pe_weight_val = '0;
    bus.pe_image_en   = 1'b0;
    bus.pe_image_val  = '0;
    bus.pe_psum_in    = '0;
    bus.out_valid     = 1'b0;
    bus.out_data      = '0;
    case (r_state)
      StLoad: begin
        bus.w_ready = (r_wcnt < KFull);
        bus.x_ready = (r_xcnt < NFull);
      end
      StLdW: begin
        bus.pe_weight_en  = 1'b1;
        bus.pe_weight_val = r_wbuf[r_k];
      end
      StIssue: begin
        bus.pe_image_en  = 1'b1;
        bus.pe_image_val = r_xbuf[w_xidx];
        bus.pe_psum_in   = r_acc;
      end
      StOut: begin
        bus.out_valid = 1'b1;
        bus.out_data  = r_acc;
      end
      default: ;
    endcase
  end

  assign o_busy = (r_state != StIdle);
  assign o_done = r_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wcnt <= '0;
      r_xcnt <= '0;
      r_k    <= '0;
      r_o    <= '0;
      r_acc  <= '0;
      r_done <= 1'b0;
      for (int i = 0; i < int'(K); i++) r_wbuf[i] <= '0;
      for (int i = 0; i < int'(N); i++) r_xbuf[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_wcnt <= '0;
            r_xcnt <= '0;
            r_k    <= '0;
            r_o    <= '0;
            r_acc  <= '0;
          end
        end
        StLoad: begin
          if (w_w_fire) begin
            r_wbuf[KiW'(r_wcnt)] <= bus.w_data;
            r_wcnt               <= r_wcnt + WcW'(1);
          end
          if (w_x_fire) begin
            r_xbuf[XiW'(r_xcnt)] <= bus.x_data;
            r_xcnt               <= r_xcnt + XcW'(1);
          end
          if (w_load_full) begin
            r_k   <= '0;
            r_o   <= '0;
            r_acc <= '0;
          end
        end
        StCap: begin
          r_acc <= bus.pe_psum_out;
          if (r_k != KLast) r_k <= r_k + KiW'(1);
        end
        StOut: begin
          if (w_out_fire) begin
            r_acc <= '0;
            r_k   <= '0;
            if (r_o == OLast) r_done <= 1'b1;
            else              r_o    <= r_o + XiW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_row_feeder.sv
// Directed bench for pe_row_feeder with a behavioural PE closing the psum loop.
module tb_pe_row_feeder;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned PSUM_W = 32;
  localparam int unsigned K      = 3;
  localparam int unsigned N      = 8;
  localparam int unsigned NOUT   = N - K + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;

  pe_row_feeder_if #(.DATA_W(DATA_W), .PSUM_W(PSUM_W)) bus ();

  pe_row_feeder #(.DATA_W(DATA_W), .PSUM_W(PSUM_W), .K(K), .N(N)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .o_busy  (busy),
    .o_done  (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // PE: latch weight on weight_en; psum_out registered the cycle after image_en.
  logic [DATA_W-1:0] pe_wt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_wt           <= '0;
      bus.pe_psum_out <= '0;
    end else begin
      if (bus.pe_weight_en) pe_wt <= bus.pe_weight_val;
      if (bus.pe_image_en)
        bus.pe_psum_out <= PSUM_W'(pe_wt) * PSUM_W'(bus.pe_image_val) + bus.pe_psum_in;
    end
  end

  int n_vec = 0, n_err = 0;
  int n_wen = 0, n_ien = 0, n_done = 0, n_overlap = 0;

  always @(negedge clk) begin
    if (bus.pe_weight_en && bus.pe_image_en) n_overlap++;
    if (bus.pe_weight_en) n_wen++;
    if (bus.pe_image_en)  n_ien++;
    if (done)             n_done++;
  end

  logic [DATA_W-1:0] wv   [K];
  logic [DATA_W-1:0] xv   [N];
  logic [PSUM_W-1:0] expv [NOUT];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Hand-computed results: basic row gives 14,20,...,44; all-ones wraps to 0xFFFA0003.
  task automatic set_row(input bit wrap);
    for (int i = 0; i < int'(K); i++) wv[i] = wrap ? 16'hFFFF : DATA_W'(i + 1);
    for (int i = 0; i < int'(N); i++) xv[i] = wrap ? 16'hFFFF : DATA_W'(i + 1);
    for (int o = 0; o < int'(NOUT); o++) expv[o] = wrap ? 32'hFFFA_0003 : PSUM_W'(14 + 6 * o);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rdy"}, {bus.w_ready, bus.x_ready}, 0);
    check({tag, "_en"}, {bus.pe_weight_en, bus.pe_image_en}, 0);
    check({tag, "_vals"}, {bus.pe_weight_val, bus.pe_image_val}, 0);
    check({tag, "_psum_in"}, bus.pe_psum_in, 0);
    check({tag, "_out"}, {bus.out_valid, bus.out_data}, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load_row(input bit interleave);
    int wi = 0, xi = 0, cyc = 0;
    while ((wi < int'(K) || xi < int'(N)) && cyc < 300) begin
      bus.w_valid = (wi < int'(K)) && (!interleave || (xi >= 4 && $urandom_range(0, 2) != 0));
      bus.x_valid = (xi < int'(N)) && (!interleave || $urandom_range(0, 2) != 0);
      bus.w_data  = wv[(wi < int'(K)) ? wi : 0];
      bus.x_data  = xv[(xi < int'(N)) ? xi : 0];
      @(negedge clk);
      check("w_ready", bus.w_ready, wi < int'(K));
      check("x_ready", bus.x_ready, xi < int'(N));
      if (bus.w_valid && bus.w_ready) wi++;
      if (bus.x_valid && bus.x_ready) xi++;
      @(posedge clk); #1;
      cyc++;
    end
    check("load_in_budget", cyc < 300, 1);
    bus.w_valid = 1'b0;
    bus.x_valid = 1'b0;
    @(negedge clk);
    check("readies_full", {bus.w_ready, bus.x_ready}, 0);
    @(posedge clk); #1;
  endtask

  task automatic collect_row(input bit stall, input bit start_in_out);
    int n = 0, cyc = 0;
    bit stalled = 0;
    logic [PSUM_W-1:0] held = '0;
    while (n < int'(NOUT) && cyc < 1000) begin
      bus.out_ready = stall ? (cyc % 3 == 0) : 1'b1;
      @(negedge clk);
      if (bus.out_valid) begin
        if (start_in_out && n == 2) start = 1'b1;
        if (stalled) check("out_stable", bus.out_data, held);
        if (bus.out_ready) begin
          check("out_data", bus.out_data, expv[n]);
          n++;
          stalled = 0;
        end else begin
          stalled = 1;
          held    = bus.out_data;
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check("out_count", n, NOUT);
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("done_pulse", done, 1);
    check("busy_at_done", busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("done_single", done, 0);
    @(posedge clk); #1;
  endtask

  task automatic run_row(input bit interleave, input bit stall, input bit start_in_out);
    int wen0 = n_wen, ien0 = n_ien, done0 = n_done;
    pulse_start();
    check("busy_load", busy, 1);
    load_row(interleave);
    collect_row(stall, start_in_out);
    repeat (3) @(posedge clk);
    #1;
    check("weight_en_count", n_wen - wen0, K * NOUT);
    check("image_en_count", n_ien - ien0, K * NOUT);
    check("done_count", n_done - done0, 1);
    check("idle_after_row", busy, 0);
  endtask

  task automatic reset_mid_compute();
    int seen = 0, cyc = 0;
    pulse_start();
    load_row(1'b0);
    while (seen < 2 && cyc < 100) begin
      @(negedge clk);
      if (bus.pe_image_en) seen++;
      cyc++;
    end
    check("second_issue_seen", seen, 2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_rst", busy, 0);
  endtask

  initial begin
    bus.w_valid   = 1'b0;
    bus.x_valid   = 1'b0;
    bus.w_data    = '0;
    bus.x_data    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_row(1'b0);
    run_row(1'b0, 1'b0, 1'b0);  // basic
    run_row(1'b0, 1'b1, 1'b0);  // output backpressure
    run_row(1'b1, 1'b0, 1'b0);  // x before w, gapped valids
    set_row(1'b1);
    run_row(1'b0, 1'b0, 1'b0);  // wraparound
    set_row(1'b0);
    reset_mid_compute();
    run_row(1'b0, 1'b0, 1'b0);
    run_row(1'b0, 1'b0, 1'b1);  // start pulsed during OUT

    check("en_overlap", n_overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
